// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the generic pipeline stage: default widths, control-word
// bit positions and the ID/EX data-word field layout.
package pipe_pkg;

  localparam int DEF_CTRL_W = 10;
  localparam int DEF_DATA_W = 154;
  localparam int DEF_CNT_W  = 16;

  // Control word bit positions
  localparam int REGDST    = 0;
  localparam int ALUSRC    = 1;
  localparam int MEMTOREG  = 2;
  localparam int REGWRITE  = 3;
  localparam int MEMREAD   = 4;
  localparam int MEMWRITE  = 5;
  localparam int BRANCH    = 6;
  localparam int ALUOP_LSB = 7;
  localparam int ALUOP_MSB = 8;
  localparam int SPARE     = 9;

  // ID/EX data word layout, LSB first; pc_plus4 drops bit 0, which is always zero
  localparam int FUNCT_LSB    = 0;
  localparam int FUNCT_W      = 6;
  localparam int RD_LSB       = 6;
  localparam int RT_LSB       = 11;
  localparam int RS_LSB       = 16;
  localparam int REG_W        = 5;
  localparam int SIGN_EXT_LSB = 21;
  localparam int RT_DATA_LSB  = 53;
  localparam int RS_DATA_LSB  = 85;
  localparam int WORD_W       = 32;
  localparam int PC_PLUS4_LSB = 117;
  localparam int PC_PLUS4_W   = 31;
  localparam int OPCODE_LSB   = 148;
  localparam int OPCODE_W     = 6;

  // True when a control word would cause an architectural side effect downstream
  function automatic logic ctrl_side_effect(input logic [DEF_CTRL_W-1:0] ctrl);
    return ctrl[REGWRITE] | ctrl[MEMWRITE] | ctrl[BRANCH];
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one control word and one data word.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One holding slot of the stage: valid flag plus control and data registers.
// Clear wins over load and zeroes the control word but keeps the data word.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Slot state update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage with valid/ready handshake, optional skid slot,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  pipe_stage_skid_if.slave   up_if,
  pipe_stage_skid_if.master  dn_if,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  logic              in_ready_s;
  logic              in_fire_s;
  logic              main_valid_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [DATA_W-1:0] main_data_s;
  logic              main_load_s;
  logic              main_clear_s;
  logic [CTRL_W-1:0] main_ctrl_in_s;
  logic [DATA_W-1:0] main_data_in_s;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign in_fire_s = up_if.valid & in_ready_s;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load_s),
    .clear_i (main_clear_s),
    .ctrl_i  (main_ctrl_in_s),
    .data_i  (main_data_in_s),
    .valid_o (main_valid_s),
    .ctrl_o  (main_ctrl_s),
    .data_o  (main_data_s)
  );

  if (SKID != 0) begin : g_skid
    logic              main_free_s;
    logic              skid_valid_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic              skid_valid_d;
    logic              in_ready_q;

    assign main_free_s = !main_valid_s || dn_if.ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load_i  (skid_load_s),
      .clear_i (skid_clear_s),
      .ctrl_i  (up_if.ctrl),
      .data_i  (up_if.data),
      .valid_o (skid_valid_s),
      .ctrl_o  (skid_ctrl_s),
      .data_o  (skid_data_s)
    );

    // Steering: the skid entry is always older than the input, so it refills main first
    always_comb begin
      main_load_s    = 1'b0;
      main_clear_s   = 1'b0;
      skid_load_s    = 1'b0;
      skid_clear_s   = 1'b0;
      main_ctrl_in_s = up_if.ctrl;
      main_data_in_s = up_if.data;
      if (flush_i) begin
        main_clear_s = 1'b1;
        skid_clear_s = 1'b1;
      end else begin
        if (main_free_s) begin
          if (skid_valid_s) begin
            main_load_s    = 1'b1;
            main_ctrl_in_s = skid_ctrl_s;
            main_data_in_s = skid_data_s;
            skid_clear_s   = 1'b1;
          end else if (in_fire_s) begin
            main_load_s = 1'b1;
          end else begin
            main_clear_s = 1'b1;
          end
        end else begin
          main_load_s = 1'b0;
        end
        if (in_fire_s && !(main_free_s && !skid_valid_s)) begin
          skid_load_s  = 1'b1;
          skid_clear_s = 1'b0;
        end else begin
          skid_load_s = 1'b0;
        end
      end
    end

    assign skid_valid_d = !skid_clear_s && (skid_load_s || skid_valid_s);

    // Registered ready keeps out_ready off the upstream timing path
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= !skid_valid_d;
      end
    end

    assign in_ready_s = in_ready_q;
  end else begin : g_noskid
    logic out_fire_s;

    assign out_fire_s     = main_valid_s & dn_if.ready;
    assign in_ready_s     = !main_valid_s || dn_if.ready;
    assign main_load_s    = !flush_i && in_fire_s;
    assign main_clear_s   = flush_i || (out_fire_s && !in_fire_s);
    assign main_ctrl_in_s = up_if.ctrl;
    assign main_data_in_s = up_if.data;
  end

  // Stall counter saturates and is only cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (main_valid_s && !dn_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign up_if.ready = in_ready_s;
  assign dn_if.valid = main_valid_s;
  assign dn_if.ctrl  = main_ctrl_s;
  assign dn_if.data  = main_data_s;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance (4-bit stall counter) and a
// single-slot instance, each checked by an input-recorded scoreboard plus directed checks.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CW = 10;
  localparam int DW = 154;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic flush0;
  logic flush1;
  logic [3:0]  stall0;
  logic [15:0] stall1;
  int n_tests = 0;
  int n_fail  = 0;
  ent_t q0[$];
  ent_t q1[$];

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up1 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn1 ();

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .reset(reset), .flush_i(flush0),
    .up_if(up0.slave), .dn_if(dn0.master), .stall_cnt_o(stall0)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .reset(reset), .flush_i(flush1),
    .up_if(up1.slave), .dn_if(dn1.master), .stall_cnt_o(stall1)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [7:0] k);
    logic [159:0] t;
    t = {20{k}};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [CW-1:0] c, input logic [7:0] k);
    up0.valid = v;
    up0.ctrl  = c;
    up0.data  = pat(k);
  endtask

  task automatic drive1(input logic v, input logic [CW-1:0] c, input logic [7:0] k);
    up1.valid = v;
    up1.ctrl  = c;
    up1.data  = pat(k);
  endtask

  // Scoreboard monitor for the skid instance
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
    end else begin
      if (dn0.valid && dn0.ready) begin
        n_tests++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb0_unexpected: got ctrl %0h with nothing expected", dn0.ctrl);
        end else begin
          ent_t e;
          e = q0.pop_front();
          if (dn0.ctrl !== e.c || dn0.data !== e.d) begin
            n_fail++;
            $display("FAIL sb0_order: got ctrl %0h data %0h expected ctrl %0h data %0h",
                     dn0.ctrl, dn0.data, e.c, e.d);
          end
        end
      end
      if (!dn0.valid) chk("sb0_bubble_ctrl", 160'(dn0.ctrl), 160'd0);
      if (flush0) q0.delete();
      else if (up0.valid && up0.ready) q0.push_back('{c: up0.ctrl, d: up0.data});
    end
  end

  // Scoreboard monitor for the single-slot instance
  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
    end else begin
      if (dn1.valid && dn1.ready) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_unexpected: got ctrl %0h with nothing expected", dn1.ctrl);
        end else begin
          ent_t e;
          e = q1.pop_front();
          if (dn1.ctrl !== e.c || dn1.data !== e.d) begin
            n_fail++;
            $display("FAIL sb1_order: got ctrl %0h data %0h expected ctrl %0h data %0h",
                     dn1.ctrl, dn1.data, e.c, e.d);
          end
        end
      end
      if (!dn1.valid) chk("sb1_bubble_ctrl", 160'(dn1.ctrl), 160'd0);
      if (flush1) q1.delete();
      else if (up1.valid && up1.ready) q1.push_back('{c: up1.ctrl, d: up1.data});
    end
  end

  initial begin
    reset = 1'b1;
    flush0 = 1'b0;
    flush1 = 1'b0;
    drive0(1'b0, 10'h000, 8'h00);
    drive1(1'b0, 10'h000, 8'h00);
    dn0.ready = 1'b0;
    dn1.ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_out_valid", 160'(dn0.valid), 160'd0);
    chk("rst_out_ctrl", 160'(dn0.ctrl), 160'd0);
    chk("rst_out_data", 160'(dn0.data), 160'd0);
    chk("rst_stall", 160'(stall0), 160'd0);
    chk("rst_in_ready", 160'(up0.ready), 160'd1);
    chk("rst_in_ready_noskid", 160'(up1.ready), 160'd1);

    // 1: single entry, one-cycle latency
    dn0.ready = 1'b1;
    drive0(1'b1, 10'h0AB, 8'hA5);
    tick(1);
    chk("t1_valid", 160'(dn0.valid), 160'd1);
    chk("t1_ctrl", 160'(dn0.ctrl), 160'h0AB);
    chk("t1_data", 160'(dn0.data), 160'(pat(8'hA5)));
    chk("t1_in_ready", 160'(up0.ready), 160'd1);
    drive0(1'b0, 10'h000, 8'h00);
    tick(1);

    // 2: 8-entry stream at full rate, no gaps
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, 10'(10'h100 + i), 8'(8'h10 + i));
      tick(1);
      chk("t2_no_gap", 160'(dn0.valid), 160'd1);
    end
    drive0(1'b0, 10'h000, 8'h00);
    tick(1);
    chk("t2_drained", 160'(dn0.valid), 160'd0);
    chk("t2_stall", 160'(stall0), 160'd0);

    // 3: backpressure fills the skid slot, then drains in order
    dn0.ready = 1'b0;
    drive0(1'b1, 10'h0A1, 8'hA1);
    tick(1);
    chk("t3_ready_after_a", 160'(up0.ready), 160'd1);
    drive0(1'b1, 10'h0B2, 8'hB2);
    tick(1);
    chk("t3_ready_after_b", 160'(up0.ready), 160'd0);
    chk("t3_head_a", 160'(dn0.ctrl), 160'h0A1);
    drive0(1'b1, 10'h0C3, 8'hC3);
    tick(2);
    chk("t3_c_held", 160'(up0.ready), 160'd0);
    chk("t3_stall", 160'(stall0), 160'd3);
    dn0.ready = 1'b1;
    tick(1);
    chk("t3_head_b", 160'(dn0.ctrl), 160'h0B2);
    chk("t3_ready_reopen", 160'(up0.ready), 160'd1);
    tick(1);
    chk("t3_head_c", 160'(dn0.ctrl), 160'h0C3);
    drive0(1'b0, 10'h000, 8'h00);
    tick(1);
    chk("t3_empty", 160'(dn0.valid), 160'd0);
    chk("t3_stall_final", 160'(stall0), 160'd3);

    // 4a: flush with both slots full; D offered but must never appear
    dn0.ready = 1'b0;
    drive0(1'b1, 10'h0E1, 8'hE1);
    tick(1);
    drive0(1'b1, 10'h0E2, 8'hE2);
    tick(1);
    drive0(1'b1, 10'h0DD, 8'hDD);
    flush0 = 1'b1;
    tick(1);
    flush0 = 1'b0;
    drive0(1'b0, 10'h000, 8'h00);
    chk("t4_valid", 160'(dn0.valid), 160'd0);
    chk("t4_ctrl", 160'(dn0.ctrl), 160'd0);
    chk("t4_in_ready", 160'(up0.ready), 160'd1);
    chk("t4_data_held", 160'(dn0.data), 160'(pat(8'hE1)));
    // 4b: an accepted entry in the flush cycle is discarded
    drive0(1'b1, 10'h0F1, 8'hF1);
    tick(1);
    drive0(1'b1, 10'h0DD, 8'hDD);
    flush0 = 1'b1;
    tick(1);
    flush0 = 1'b0;
    drive0(1'b0, 10'h000, 8'h00);
    chk("t4b_valid", 160'(dn0.valid), 160'd0);
    dn0.ready = 1'b1;
    tick(2);
    chk("t4b_d_killed", 160'(dn0.valid), 160'd0);

    // 5: stall counter saturation, survives flush, cleared by reset
    dn0.ready = 1'b0;
    drive0(1'b1, 10'h055, 8'h55);
    tick(1);
    drive0(1'b0, 10'h000, 8'h00);
    tick(20);
    chk("t5_saturate", 160'(stall0), 160'd15);
    flush0 = 1'b1;
    tick(1);
    flush0 = 1'b0;
    chk("t5_flush_keeps", 160'(stall0), 160'd15);
    reset = 1'b1;
    #1;
    chk("t5_reset_clears", 160'(stall0), 160'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // 6: single-slot variant, combinational ready and bubble-free replacement
    dn1.ready = 1'b0;
    drive1(1'b1, 10'h011, 8'h11);
    tick(1);
    chk("t6_valid", 160'(dn1.valid), 160'd1);
    chk("t6_ready_low", 160'(up1.ready), 160'd0);
    drive1(1'b1, 10'h022, 8'h22);
    tick(1);
    chk("t6_hold_x", 160'(dn1.ctrl), 160'h011);
    chk("t6_stall", 160'(stall1), 160'd1);
    dn1.ready = 1'b1;
    #1;
    chk("t6_ready_comb", 160'(up1.ready), 160'd1);
    tick(1);
    chk("t6_y_valid", 160'(dn1.valid), 160'd1);
    chk("t6_y_ctrl", 160'(dn1.ctrl), 160'h022);
    drive1(1'b1, 10'h033, 8'h33);
    tick(1);
    chk("t6_z_ctrl", 160'(dn1.ctrl), 160'h033);
    drive1(1'b0, 10'h000, 8'h00);
    tick(1);
    chk("t6_empty", 160'(dn1.valid), 160'd0);
    chk("t6_stall_final", 160'(stall1), 160'd1);

    tick(2);
    chk("sb0_leftover", 160'(q0.size()), 160'd0);
    chk("sb1_leftover", 160'(q1.size()), 160'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
